// File: rtl/imul_sequencer.sv
// IMUL sequencer: unsigned WIDTHxWIDTH radix-2 shift-add multiply over WIDTH cycles,
// with fetch stall and a single write-back strobe on completion.
module imul_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 iStart,
  input  logic [WIDTH-1:0]     iA,
  input  logic [WIDTH-1:0]     iB,
  input  logic [7:0]           iDest,
  output logic                 oBusy,
  output logic                 oStall,
  output logic                 oDone,
  output logic                 oWriteEnable,
  output logic [7:0]           oWriteAddress,
  output logic [2*WIDTH-1:0]   oResult,
  output logic                 oOverflow
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [2*WIDTH-1:0]   r_m;
  logic [WIDTH-1:0]     r_q;
  logic [2*WIDTH-1:0]   r_p;
  logic [CW-1:0]        r_count;

  logic [2*WIDTH-1:0]   w_sum;
  logic                 w_zero_op;

  // Partial add for the current multiplier bit; the product cannot exceed 2*WIDTH bits.
  assign w_sum     = r_p + (r_q[0] ? r_m : {(2*WIDTH){1'b0}});
  assign w_zero_op = (iA == {WIDTH{1'b0}}) || (iB == {WIDTH{1'b0}});

  // Stall is held low during reset so fetch is never frozen by a stale state.
  assign oStall = !Reset && (((r_state == S_IDLE) && iStart) || (r_state == S_RUN));

  // Sequencer state, datapath and registered outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state       <= S_IDLE;
      r_m           <= {(2*WIDTH){1'b0}};
      r_q           <= {WIDTH{1'b0}};
      r_p           <= {(2*WIDTH){1'b0}};
      r_count       <= {CW{1'b0}};
      oBusy         <= 1'b0;
      oDone         <= 1'b0;
      oWriteEnable  <= 1'b0;
      oWriteAddress <= 8'd0;
      oResult       <= {(2*WIDTH){1'b0}};
      oOverflow     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          oDone        <= 1'b0;
          oWriteEnable <= 1'b0;
          if (iStart) begin
            r_m           <= {{WIDTH{1'b0}}, iA};
            r_q           <= iB;
            r_p           <= {(2*WIDTH){1'b0}};
            r_count       <= CW'(WIDTH - 1);
            oWriteAddress <= iDest;
            oBusy         <= 1'b1;
            if (w_zero_op) begin
              // Zero operand: the product is known, skip the add loop.
              r_state      <= S_DONE;
              oResult      <= {(2*WIDTH){1'b0}};
              oOverflow    <= 1'b0;
              oDone        <= 1'b1;
              oWriteEnable <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end else begin
            oBusy <= 1'b0;
          end
        end
        S_RUN: begin
          r_p     <= w_sum;
          r_m     <= r_m << 1;
          r_q     <= r_q >> 1;
          r_count <= r_count - CW'(1);
          if (r_count == {CW{1'b0}}) begin
            r_state      <= S_DONE;
            oResult      <= w_sum;
            oOverflow    <= |w_sum[2*WIDTH-1:WIDTH];
            oDone        <= 1'b1;
            oWriteEnable <= 1'b1;
          end else begin
            r_state <= S_RUN;
          end
        end
        S_DONE: begin
          r_state      <= S_IDLE;
          oBusy        <= 1'b0;
          oDone        <= 1'b0;
          oWriteEnable <= 1'b0;
        end
        default: begin
          r_state      <= S_IDLE;
          oBusy        <= 1'b0;
          oDone        <= 1'b0;
          oWriteEnable <= 1'b0;
        end
      endcase
    end
  end

endmodule
